// File: rtl/pim_shift_acc_pkg.sv
// Shared definitions for the bit-serial shift-accumulate block.
//   clogb2 : ceil(log2(n)) with a floor of 1, so that counter widths are never zero
//   state_e: controller state encoding
//   out_w  : result width derived from the ADC width and the bit-serial depth
package pim_shift_acc_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StHold  = 2'd2
    } state_e;

    function automatic int unsigned clogb2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    // One bit of headroom above ADC_P+INPUT_P keeps signed results representable.
    function automatic int unsigned out_w(input int unsigned adc_p, input int unsigned input_p);
        return adc_p + input_p + 1;
    endfunction

endpackage

// File: rtl/pim_shift_add.sv
// Combinational shifted add/subtract of one bit-plane partial sum into the accumulator.
//   acc_i       : current accumulator value (two's complement, OUT_W bits)
//   in_data_i   : unsigned partial sum of the current plane
//   plane_cnt_i : index of the current plane (shift amount)
//   sum_o       : acc_i +/- (in_data_i << plane_cnt_i)
module pim_shift_add
    import pim_shift_acc_pkg::*;
#(
    parameter int unsigned ADC_P     = 4,
    parameter int unsigned INPUT_P   = 4,
    parameter int unsigned SIGNED_IN = 0,
    parameter int unsigned OUT_W     = out_w(ADC_P, INPUT_P),
    parameter int unsigned CNT_W     = clogb2(INPUT_P)
) (
    input  logic [OUT_W-1:0] acc_i,
    input  logic [ADC_P-1:0] in_data_i,
    input  logic [CNT_W-1:0] plane_cnt_i,
    output logic [OUT_W-1:0] sum_o
);

    logic [OUT_W-1:0] term;
    logic             last_plane;

    always_comb begin
        term       = OUT_W'(in_data_i) << plane_cnt_i;
        last_plane = (plane_cnt_i == CNT_W'(INPUT_P - 1));
        // With two's-complement inputs the MSB plane has weight -2^(INPUT_P-1).
        if ((SIGNED_IN != 0) && last_plane) begin
            sum_o = acc_i - term;
        end else begin
            sum_o = acc_i + term;
        end
    end

endmodule

// File: rtl/pim_shift_acc.sv
// Bit-serial shift-accumulate for processing-in-memory dot products. Consumes INPUT_P
// ADC partial sums (LSB plane first) and presents the weighted sum as one result.
//   clk, rst             : clock and asynchronous active-low reset
//   start, abort         : begin a new accumulation / discard and return to idle
//   in_valid, in_data    : one plane partial sum per accepted beat; in_ready high in ACCUM
//   out_valid, out_data  : completed result, held until out_ready
//   busy                 : high while accumulating or holding a result
module pim_shift_acc
    import pim_shift_acc_pkg::*;
#(
    parameter int unsigned ADC_P     = 4,
    parameter int unsigned INPUT_P   = 4,
    parameter int unsigned SIGNED_IN = 0,
    localparam int unsigned OUT_W    = out_w(ADC_P, INPUT_P)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [ADC_P-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    input  logic             out_ready,
    output logic             busy
);

    localparam int unsigned CNT_W = clogb2(INPUT_P);

    state_e           state_q, state_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] sum;
    logic             last_plane;

    pim_shift_add #(
        .ADC_P     (ADC_P),
        .INPUT_P   (INPUT_P),
        .SIGNED_IN (SIGNED_IN),
        .OUT_W     (OUT_W),
        .CNT_W     (CNT_W)
    ) u_shift_add (
        .acc_i       (acc_q),
        .in_data_i   (in_data),
        .plane_cnt_i (cnt_q),
        .sum_o       (sum)
    );

    assign last_plane = (cnt_q == CNT_W'(INPUT_P - 1));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = StIdle;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StAccum;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end
                end
                StAccum: begin
                    if (in_valid) begin
                        acc_d = sum;
                        if (last_plane) begin
                            state_d = StHold;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                StHold: begin
                    // A start coinciding with the handshake restarts without an idle bubble.
                    if (out_ready) begin
                        if (start) begin
                            state_d = StAccum;
                            acc_d   = '0;
                            cnt_d   = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // The accumulator itself is the result register; it is frozen in HOLD.
    assign out_data  = acc_q;
    assign out_valid = (state_q == StHold);
    assign in_ready  = (state_q == StAccum);
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_pim_shift_acc.sv
// Directed bench for pim_shift_acc: an unsigned and a signed instance share all inputs,
// each checked against hand-computed results.
module tb_pim_shift_acc;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       in_valid;
    logic [3:0] in_data;
    logic       out_ready;

    logic       in_ready_u, out_valid_u, busy_u;
    logic [8:0] out_data_u;
    logic       in_ready_s, out_valid_s, busy_s;
    logic [8:0] out_data_s;

    int n_checks;
    int n_fail;

    pim_shift_acc #(
        .ADC_P     (4),
        .INPUT_P   (4),
        .SIGNED_IN (0)
    ) dut_u (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready_u),
        .out_valid (out_valid_u),
        .out_data  (out_data_u),
        .out_ready (out_ready),
        .busy      (busy_u)
    );

    pim_shift_acc #(
        .ADC_P     (4),
        .INPUT_P   (4),
        .SIGNED_IN (1)
    ) dut_s (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready_s),
        .out_valid (out_valid_s),
        .out_data  (out_data_s),
        .out_ready (out_ready),
        .busy      (busy_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] planes;  // {p3, p2, p1, p0}, p0 sent first
        logic [7:0]  gap;     // idle cycles (with start pulses) after the second beat
        logic [7:0]  stall;   // cycles out_ready is held low in HOLD
        logic [8:0]  exp_u;
        logic [8:0]  exp_s;
    } vec_t;

    vec_t vecs [6];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("in_ready_after_start", {30'd0, in_ready_s, in_ready_u}, 32'h3);
    endtask

    task automatic feed(input logic [15:0] planes, input int gap);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = planes[i*4 +: 4];
            cyc();
            in_valid = 1'b0;
            in_data  = 4'hF;
            if (i == 2) chk("no_early_valid", {31'd0, out_valid_u}, 32'd0);
            if (i == 1) begin
                for (int g = 0; g < gap; g++) begin
                    start = 1'b1;
                    cyc();
                    start = 1'b0;
                    chk("gap_in_ready", {31'd0, in_ready_u}, 32'd1);
                end
            end
        end
    endtask

    task automatic check_hold(input logic [8:0] eu, input logic [8:0] es, input int stall);
        chk("out_valid_u", {31'd0, out_valid_u}, 32'd1);
        chk("out_valid_s", {31'd0, out_valid_s}, 32'd1);
        chk("out_data_u", {23'd0, out_data_u}, {23'd0, eu});
        chk("out_data_s", {23'd0, out_data_s}, {23'd0, es});
        chk("hold_in_ready", {31'd0, in_ready_u}, 32'd0);
        for (int k = 0; k < stall; k++) begin
            start = 1'b1;  // ignored without handshake
            cyc();
            start = 1'b0;
            chk("stall_data", {23'd0, out_data_u}, {23'd0, eu});
            chk("stall_valid", {31'd0, out_valid_u}, 32'd1);
            chk("stall_in_ready", {31'd0, in_ready_u}, 32'd0);
        end
    endtask

    task automatic handshake(input logic with_start);
        out_ready = 1'b1;
        start     = with_start;
        cyc();
        out_ready = 1'b0;
        start     = 1'b0;
        chk("valid_drop", {31'd0, out_valid_u}, 32'd0);
        chk("post_hs_in_ready", {31'd0, in_ready_u}, {31'd0, with_start});
        chk("post_hs_busy", {31'd0, busy_u}, {31'd0, with_start});
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        out_ready = 1'b0;

        vecs[0] = '{planes: 16'h2013, gap: 8'd0, stall: 8'd0, exp_u: 9'd21,  exp_s: 9'h1F5};
        vecs[1] = '{planes: 16'hFFFF, gap: 8'd0, stall: 8'd5, exp_u: 9'd225, exp_s: 9'h1F1};
        vecs[2] = '{planes: 16'h1001, gap: 8'd0, stall: 8'd0, exp_u: 9'd9,   exp_s: 9'h1F9};
        vecs[3] = '{planes: 16'h2013, gap: 8'd3, stall: 8'd0, exp_u: 9'd21,  exp_s: 9'h1F5};
        vecs[4] = '{planes: 16'hF000, gap: 8'd1, stall: 8'd2, exp_u: 9'd120, exp_s: 9'h188};
        vecs[5] = '{planes: 16'h0000, gap: 8'd0, stall: 8'd0, exp_u: 9'd0,   exp_s: 9'd0};

        #3;
        chk("rst_out_valid", {31'd0, out_valid_u}, 32'd0);
        chk("rst_out_data", {23'd0, out_data_u}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready_u}, 32'd0);
        chk("rst_busy", {31'd0, busy_s}, 32'd0);
        #9 rst = 1'b1;
        cyc();

        // Beats offered in IDLE are ignored.
        in_valid = 1'b1;
        in_data  = 4'd9;
        cyc();
        in_valid = 1'b0;
        chk("idle_in_ready", {31'd0, in_ready_u}, 32'd0);
        chk("idle_acc", {23'd0, out_data_u}, 32'd0);

        for (int v = 0; v < 6; v++) begin
            do_start();
            feed(vecs[v].planes, int'(vecs[v].gap));
            check_hold(vecs[v].exp_u, vecs[v].exp_s, int'(vecs[v].stall));
            handshake(1'b0);
        end

        // Abort after two beats; abort wins over a simultaneous beat and start.
        do_start();
        in_valid = 1'b1;
        in_data  = 4'd7;
        cyc();
        cyc();
        abort = 1'b1;
        start = 1'b1;
        cyc();
        abort    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        chk("abort_busy", {31'd0, busy_u}, 32'd0);
        chk("abort_acc", {23'd0, out_data_u}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("abort_no_valid", {30'd0, out_valid_s, out_valid_u}, 32'd0);
        end
        do_start();
        feed(16'h1111, 0);
        check_hold(9'd15, 9'h1FF, 0);
        handshake(1'b0);

        // Asynchronous reset while holding a result.
        do_start();
        feed(16'h3333, 0);
        chk("pre_rst_valid", {31'd0, out_valid_u}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_valid", {30'd0, out_valid_s, out_valid_u}, 32'd0);
        chk("async_rst_data", {23'd0, out_data_u}, 32'd0);
        chk("async_rst_busy", {31'd0, busy_u}, 32'd0);
        #2 rst = 1'b1;
        do_start();  // first edge after release accepts start
        feed(16'h0002, 0);
        check_hold(9'd2, 9'd2, 0);
        handshake(1'b1);  // back-to-back restart
        feed(16'h1111, 0);
        check_hold(9'd15, 9'h1FF, 0);
        handshake(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pim_shift_acc.md
PIM_SHIFT_ACC -- requirements
Module: pim_shift_acc

Interface
REQ-001 Parameter ADC_P, default 4, width of one bit-plane partial sum from the crossbar column ADC.
REQ-002 Parameter INPUT_P, default 4, number of input bit-planes per feature (bit-serial depth).
REQ-003 Parameter SIGNED_IN, default 0; 1 means the MSB plane carries negative weight (two's-complement inputs).
REQ-004 Derived OUT_W = ADC_P+INPUT_P+1; CNT_W = clogb2(INPUT_P).
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle request to begin a new accumulation.
REQ-008 abort  input  1  discard the current accumulation and return to idle.
REQ-009 in_valid  input  1  in_data carries one bit-plane partial sum.
REQ-010 in_data  input  ADC_P  unsigned partial sum for the current plane, LSB plane first.
REQ-011 in_ready  output  1  block accepts in_data this cycle.
REQ-012 out_valid  output  1  out_data holds a completed result.
REQ-013 out_data  output  OUT_W  two's-complement accumulated dot product.
REQ-014 out_ready  input  1  consumer accepts out_data.
REQ-015 busy  output  1  high in ACCUM or HOLD.

Function
REQ-016 FSM states: IDLE, ACCUM, HOLD.
REQ-017 IDLE: start=1 -> ACCUM, acc cleared to 0, plane_cnt cleared to 0; in_valid ignored.
REQ-018 in_ready = 1 only in ACCUM.
REQ-019 Beat accepted when in_valid&&in_ready; acc += zero-extended in_data << plane_cnt; plane_cnt += 1.
REQ-020 SIGNED_IN=1 and plane_cnt==INPUT_P-1: the term is subtracted instead of added.
REQ-021 No in_valid in ACCUM: acc and plane_cnt hold (gaps allowed).
REQ-022 Beat accepted with plane_cnt==INPUT_P-1: next state HOLD, out_data = final acc, out_valid=1 on the following cycle (latency 1 cycle after the last beat).
REQ-023 HOLD: out_data and out_valid stable until out_valid&&out_ready; then -> IDLE.
REQ-024 HOLD handshake with start=1 in the same cycle: go directly to ACCUM with acc/plane_cnt cleared (back-to-back, no idle bubble).
REQ-025 start in ACCUM or in HOLD without handshake: ignored.
REQ-026 abort=1 in any state: -> IDLE next cycle, out_valid=0, acc cleared; abort has priority over start and beats.
REQ-027 Arithmetic width OUT_W; the range (2^ADC_P-1)(2^INPUT_P-1) cannot overflow; no saturation.
REQ-028 SIGNED_IN=0: out_data MSB is always 0.

Reset
REQ-029 rst=0 asynchronously forces: state IDLE, acc 0, plane_cnt 0, out_valid 0, out_data 0, in_ready 0, busy 0.
REQ-030 Reset mid-ACCUM or mid-HOLD discards partial or pending results; no output handshake follows.
REQ-031 Reset release is synchronous to clk; the first start is accepted on the first edge with rst=1.

Structure
REQ-032 The shared package holds clogb2, the state encoding (IDLE=0, ACCUM=1, HOLD=2), and the OUT_W derivation.
REQ-033 One sub-module, pim_shift_add: combinational shifted add/subtract of in_data into acc, selected by plane_cnt and SIGNED_IN.
REQ-034 Upstream connection: in_data is driven by the bit-serial conv stage's ADC output, one plane per cycle.

Verification (ADC_P=4, INPUT_P=4)
REQ-035 SIGNED_IN=0, start, planes 3,1,0,2 back-to-back -> out_valid one cycle after the 4th beat, out_data=21.
REQ-036 SIGNED_IN=0, planes 15,15,15,15 -> out_data=225; with out_ready held low 5 cycles, out_data stays 225 and in_ready=0.
REQ-037 SIGNED_IN=1, planes 1,0,0,1 -> out_data=-7 (9'h1F9).
REQ-038 Planes 3,1 with an in_valid gap of 3 cycles, then 0,2 -> out_data=21; start pulses during ACCUM have no effect.
REQ-039 abort after 2 beats -> IDLE, out_valid never asserts; a new start with planes 1,1,1,1 -> out_data=15.
REQ-040 rst asserted asynchronously during HOLD -> out_valid=0 immediately; after release, start with planes 2,0,0,0 -> out_data=2; handshake with start in the same cycle -> re-enters ACCUM with no bubble.
